// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, abort detection, byte assembly.
// Define HDLC_RX_MAXLEN_EN to enable the MAX_BYTES frame length check.
module hdlc_rx_deframer #(
    parameter int MAX_BYTES = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Rx,
    input  logic       RxEN,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_EoF,
    output logic [7:0] Rx_FrameSize,
    output logic       Rx_ValidFrame,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_FrameError,
    output logic       ZeroDetect
);

    typedef enum logic [1:0] {IDLE, FLAG, FRAME} state_t;

    state_t      state, state_n;
    logic [2:0]  ones, ones_n;
    logic [3:0]  bc, bc_n, bc_inc;
    logic [7:0]  sh, sh_n, shifted;
    logic [7:0]  hold, hold_n;
    logic [7:0]  count, count_n;
    logic [7:0]  data_n, size_n;
    logic        new_n, eof_n, valid_n, flag_n, abort_n, ferr_n, zero_n;
    logic        is_flag, is_abort, is_stuff;
    logic        len_chk_en, over_len;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign is_flag  = !Rx && (ones == 3'd6);
    assign is_abort =  Rx && (ones == 3'd6);
    assign is_stuff = !Rx && (ones == 3'd5);
    assign shifted  = {Rx, sh[7:1]};
    assign bc_inc   = bc + 4'd1;

`ifdef HDLC_RX_MAXLEN_EN
    assign len_chk_en = 1'b1;
`else
    assign len_chk_en = 1'b0;
`endif
    // released bytes + held byte + the byte just completed
    assign over_len = len_chk_en && ((int'({24'd0, count}) + 2) > MAX_BYTES);

    always_comb begin
        state_n = state;
        ones_n  = ones;
        bc_n    = bc;
        sh_n    = sh;
        hold_n  = hold;
        count_n = count;
        data_n  = Rx_Data;
        size_n  = Rx_FrameSize;
        new_n   = 1'b0;
        eof_n   = 1'b0;
        flag_n  = 1'b0;
        abort_n = 1'b0;
        ferr_n  = 1'b0;
        zero_n  = 1'b0;
        if (RxEN) begin
            ones_n = Rx ? ((ones == 3'd7) ? ones : ones + 3'd1) : 3'd0;
            flag_n = is_flag;
            zero_n = is_stuff && (state != IDLE);
            if (!is_stuff) begin
                sh_n = shifted;
                bc_n = bc_inc;
            end
            case (state)
                IDLE: begin
                    bc_n = 4'd0;
                    if (is_flag) state_n = FLAG;
                end
                FLAG: begin
                    if (is_flag) begin
                        bc_n = 4'd0;
                    end else if (is_abort) begin
                        bc_n    = 4'd0;
                        state_n = IDLE;
                    end else if (!is_stuff && bc_inc == 4'd8) begin
                        hold_n  = shifted;
                        bc_n    = 4'd0;
                        count_n = 8'd0;
                        state_n = FRAME;
                    end
                end
                FRAME: begin
                    if (is_flag) begin
                        // the flag's final bit completing a byte marks an aligned end
                        if (bc_inc == 4'd8) begin
                            new_n  = 1'b1;
                            eof_n  = 1'b1;
                            data_n = hold;
                            size_n = sat_inc(count);
                        end else begin
                            ferr_n = 1'b1;
                        end
                        bc_n    = 4'd0;
                        state_n = FLAG;
                    end else if (is_abort) begin
                        abort_n = 1'b1;
                        bc_n    = 4'd0;
                        state_n = IDLE;
                    end else if (!is_stuff && bc_inc == 4'd8) begin
                        bc_n = 4'd0;
                        if (over_len) begin
                            ferr_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            new_n   = 1'b1;
                            data_n  = hold;
                            count_n = sat_inc(count);
                            hold_n  = shifted;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        valid_n = (state_n == FRAME);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ones           <= 3'd0;
            bc             <= 4'd0;
            sh             <= 8'd0;
            hold           <= 8'd0;
            count          <= 8'd0;
            Rx_Data        <= 8'd0;
            Rx_NewByte     <= 1'b0;
            Rx_EoF         <= 1'b0;
            Rx_FrameSize   <= 8'd0;
            Rx_ValidFrame  <= 1'b0;
            Rx_FlagDetect  <= 1'b0;
            Rx_AbortDetect <= 1'b0;
            Rx_FrameError  <= 1'b0;
            ZeroDetect     <= 1'b0;
        end else begin
            ones           <= ones_n;
            bc             <= bc_n;
            sh             <= sh_n;
            hold           <= hold_n;
            count          <= count_n;
            Rx_Data        <= data_n;
            Rx_NewByte     <= new_n;
            Rx_EoF         <= eof_n;
            Rx_FrameSize   <= size_n;
            Rx_ValidFrame  <= valid_n;
            Rx_FlagDetect  <= flag_n;
            Rx_AbortDetect <= abort_n;
            Rx_FrameError  <= ferr_n;
            ZeroDetect     <= zero_n;
        end
    end

endmodule

// File: tb/tb_hdlc_rx_deframer.sv
// Directed bench for hdlc_rx_deframer: bit-level frames with hand-computed expectations.
module tb_hdlc_rx_deframer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Rx = 1'b0;
    logic       RxEN = 1'b0;
    logic [7:0] Rx_Data;
    logic       Rx_NewByte;
    logic       Rx_EoF;
    logic [7:0] Rx_FrameSize;
    logic       Rx_ValidFrame;
    logic       Rx_FlagDetect;
    logic       Rx_AbortDetect;
    logic       Rx_FrameError;
    logic       ZeroDetect;

    hdlc_rx_deframer dut (
        .Clk(Clk), .Rst(Rst), .Rx(Rx), .RxEN(RxEN),
        .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte), .Rx_EoF(Rx_EoF),
        .Rx_FrameSize(Rx_FrameSize), .Rx_ValidFrame(Rx_ValidFrame),
        .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
        .Rx_FrameError(Rx_FrameError), .ZeroDetect(ZeroDetect)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int gap = 0;

    int n_new, n_eof, n_flag, n_abort, n_ferr, n_zero, n_valid, n_eof_alone;
    logic [7:0] bytes_q[$];
    logic [7:0] eof_data, eof_size;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        n_new = 0; n_eof = 0; n_flag = 0; n_abort = 0; n_ferr = 0;
        n_zero = 0; n_valid = 0; n_eof_alone = 0;
        bytes_q.delete();
        eof_data = 8'h00; eof_size = 8'h00;
    endtask

    task automatic sample();
        if (Rx_NewByte) begin
            n_new++;
            bytes_q.push_back(Rx_Data);
        end
        if (Rx_EoF) begin
            n_eof++;
            eof_data = Rx_Data;
            eof_size = Rx_FrameSize;
            if (!Rx_NewByte) n_eof_alone++;
        end
        n_flag  += int'(Rx_FlagDetect);
        n_abort += int'(Rx_AbortDetect);
        n_ferr  += int'(Rx_FrameError);
        n_zero  += int'(ZeroDetect);
        n_valid += int'(Rx_ValidFrame);
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        RxEN = 1'b1;
        @(posedge Clk);
        #1;
        sample();
        RxEN = 1'b0;
        for (int g = 0; g < gap; g++) begin
            @(posedge Clk);
            #1;
            sample();
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        RxEN = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b1;
    endtask

    function automatic logic [22:0] all_outs();
        return {Rx_Data, Rx_NewByte, Rx_EoF, Rx_FrameSize, Rx_ValidFrame,
                Rx_FlagDetect, Rx_AbortDetect, Rx_FrameError, ZeroDetect};
    endfunction

    initial begin
        do_reset();
        check("reset_outputs", 32'(all_outs()), 32'd0);

        // basic two-byte frame, back-to-back bits, then with idle gaps
        for (int pass = 0; pass < 2; pass++) begin
            gap = (pass == 0) ? 0 : 3;
            do_reset();
            clear_stats();
            send_byte(8'h7E); send_byte(8'hA5); send_byte(8'h3C); send_byte(8'h7E);
            check("t1_newbytes", n_new, 2);
            check("t1_byte0", (bytes_q.size() > 0) ? bytes_q[0] : 8'hXX, 8'hA5);
            check("t1_byte1", (bytes_q.size() > 1) ? bytes_q[1] : 8'hXX, 8'h3C);
            check("t1_eof", n_eof, 1);
            check("t1_eof_alone", n_eof_alone, 0);
            check("t1_eof_data", eof_data, 8'h3C);
            check("t1_size", eof_size, 8'd2);
            check("t1_flags", n_flag, 2);
            check("t1_valid_seen", 32'(n_valid > 0), 32'd1);
            check("t1_valid_end", Rx_ValidFrame, 1'b0);
        end
        gap = 0;

        // FF needs one stuffed zero after five ones
        do_reset();
        clear_stats();
        send_byte(8'h7E);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        send_byte(8'h7E);
        check("t2_zero", n_zero, 1);
        check("t2_eof", n_eof, 1);
        check("t2_eof_data", eof_data, 8'hFF);
        check("t2_size", eof_size, 8'd1);

        // abort inside a frame
        do_reset();
        clear_stats();
        send_byte(8'h7E); send_byte(8'h11);
        for (int i = 0; i < 7; i++) send_bit(1'b1);
        check("t3_abort", n_abort, 1);
        check("t3_newbyte", n_new, 0);
        check("t3_valid", Rx_ValidFrame, 1'b0);
        send_byte(8'h55);
        check("t3_idle_newbyte", n_new, 0);

        // non-aligned close: the flag's bits complete one more byte, releasing 22,
        // then the flag lands three bits into the next byte
        do_reset();
        clear_stats();
        send_byte(8'h7E); send_byte(8'h22);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        send_byte(8'h7E);
        check("t4_ferr", n_ferr, 1);
        check("t4_eof", n_eof, 0);
        check("t4_newbyte", n_new, 1);
        check("t4_byte0", (bytes_q.size() > 0) ? bytes_q[0] : 8'hXX, 8'h22);
        check("t4_valid", Rx_ValidFrame, 1'b0);

        // repeated flags before a single byte
        do_reset();
        clear_stats();
        send_byte(8'h7E); send_byte(8'h7E); send_byte(8'h7E);
        check("t5_lead_flags", n_flag, 3);
        send_byte(8'h55); send_byte(8'h7E);
        check("t5_flags", n_flag, 4);
        check("t5_newbyte", n_new, 1);
        check("t5_eof_data", eof_data, 8'h55);
        check("t5_size", eof_size, 8'd1);

        // reset mid-frame drops it silently
        do_reset();
        clear_stats();
        send_byte(8'h7E); send_byte(8'h33);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        check("t6_valid_before", Rx_ValidFrame, 1'b1);
        Rst = 1'b0;
        @(posedge Clk);
        #1;
        check("t6_reset_outputs", 32'(all_outs()), 32'd0);
        Rst = 1'b1;
        clear_stats();
        send_byte(8'h7E); send_byte(8'h44); send_byte(8'h7E);
        check("t6_newbyte", n_new, 1);
        check("t6_eof_data", eof_data, 8'h44);
        check("t6_ferr", n_ferr, 0);

        // frame size saturates at 255
        do_reset();
        clear_stats();
        send_byte(8'h7E);
        for (int i = 0; i < 300; i++) send_byte(8'h00);
        send_byte(8'h7E);
        check("t7_newbyte", n_new, 300);
        check("t7_size_sat", eof_size, 8'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
